// File: rtl/ps2_key_ctrl.sv
// PS/2 set-2 keyboard controller: make/break/extended sequencing, modifier tracking,
// scan-code to ASCII translation and a first-word-fall-through character FIFO.
module ps2_key_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    code,
  input  logic          code_valid,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          shift_o,
  output logic          ctrl_o,
  output logic          caps_o
);

  localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CntOne   = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne = AW'(1);

  typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

  state_e      state_q;
  logic        lshift_q, rshift_q, lctrl_q, rctrl_q, caps_q, caps_held_q;
  logic        char_vld_q;
  logic [7:0]  char_q;

  logic        letter_vld, digit_vld, xlat_vld;
  logic [4:0]  letter_idx;
  logic [3:0]  digit_idx;
  logic [7:0]  xlat_char;

  assign shift_o = lshift_q | rshift_q;
  assign ctrl_o  = lctrl_q | rctrl_q;
  assign caps_o  = caps_q;

  // Translation of a non-extended make using the modifier state before this byte.
  always_comb begin
    letter_vld = 1'b0;
    letter_idx = 5'd0;
    digit_vld  = 1'b0;
    digit_idx  = 4'd0;
    xlat_vld   = 1'b0;
    xlat_char  = 8'h00;
    case (code)
      8'h1C: begin letter_vld = 1'b1; letter_idx = 5'd0;  end
      8'h32: begin letter_vld = 1'b1; letter_idx = 5'd1;  end
      8'h21: begin letter_vld = 1'b1; letter_idx = 5'd2;  end
      8'h23: begin letter_vld = 1'b1; letter_idx = 5'd3;  end
      8'h24: begin letter_vld = 1'b1; letter_idx = 5'd4;  end
      8'h2B: begin letter_vld = 1'b1; letter_idx = 5'd5;  end
      8'h34: begin letter_vld = 1'b1; letter_idx = 5'd6;  end
      8'h33: begin letter_vld = 1'b1; letter_idx = 5'd7;  end
      8'h43: begin letter_vld = 1'b1; letter_idx = 5'd8;  end
      8'h3B: begin letter_vld = 1'b1; letter_idx = 5'd9;  end
      8'h42: begin letter_vld = 1'b1; letter_idx = 5'd10; end
      8'h4B: begin letter_vld = 1'b1; letter_idx = 5'd11; end
      8'h3A: begin letter_vld = 1'b1; letter_idx = 5'd12; end
      8'h31: begin letter_vld = 1'b1; letter_idx = 5'd13; end
      8'h44: begin letter_vld = 1'b1; letter_idx = 5'd14; end
      8'h4D: begin letter_vld = 1'b1; letter_idx = 5'd15; end
      8'h15: begin letter_vld = 1'b1; letter_idx = 5'd16; end
      8'h2D: begin letter_vld = 1'b1; letter_idx = 5'd17; end
      8'h1B: begin letter_vld = 1'b1; letter_idx = 5'd18; end
      8'h2C: begin letter_vld = 1'b1; letter_idx = 5'd19; end
      8'h3C: begin letter_vld = 1'b1; letter_idx = 5'd20; end
      8'h2A: begin letter_vld = 1'b1; letter_idx = 5'd21; end
      8'h1D: begin letter_vld = 1'b1; letter_idx = 5'd22; end
      8'h22: begin letter_vld = 1'b1; letter_idx = 5'd23; end
      8'h35: begin letter_vld = 1'b1; letter_idx = 5'd24; end
      8'h1A: begin letter_vld = 1'b1; letter_idx = 5'd25; end
      8'h45: begin digit_vld = 1'b1; digit_idx = 4'd0; end
      8'h16: begin digit_vld = 1'b1; digit_idx = 4'd1; end
      8'h1E: begin digit_vld = 1'b1; digit_idx = 4'd2; end
      8'h26: begin digit_vld = 1'b1; digit_idx = 4'd3; end
      8'h25: begin digit_vld = 1'b1; digit_idx = 4'd4; end
      8'h2E: begin digit_vld = 1'b1; digit_idx = 4'd5; end
      8'h36: begin digit_vld = 1'b1; digit_idx = 4'd6; end
      8'h3D: begin digit_vld = 1'b1; digit_idx = 4'd7; end
      8'h3E: begin digit_vld = 1'b1; digit_idx = 4'd8; end
      8'h46: begin digit_vld = 1'b1; digit_idx = 4'd9; end
      8'h29: begin xlat_vld = 1'b1; xlat_char = 8'h20; end
      8'h5A: begin xlat_vld = 1'b1; xlat_char = 8'h0D; end
      8'h66: begin xlat_vld = 1'b1; xlat_char = 8'h08; end
      8'h0D: begin xlat_vld = 1'b1; xlat_char = 8'h09; end
      8'h76: begin xlat_vld = 1'b1; xlat_char = 8'h1B; end
      default: ;
    endcase
    if (letter_vld) begin
      xlat_vld = 1'b1;
      if (ctrl_o)                xlat_char = {3'b000, letter_idx} + 8'h01;
      else if (shift_o ^ caps_q) xlat_char = {3'b000, letter_idx} + 8'h41;
      else                       xlat_char = {3'b000, letter_idx} + 8'h61;
    end
    if (digit_vld) begin
      xlat_vld = 1'b1;
      if (!shift_o) begin
        xlat_char = {4'h3, digit_idx};
      end else begin
        case (digit_idx)
          4'd0:    xlat_char = 8'h29;
          4'd1:    xlat_char = 8'h21;
          4'd2:    xlat_char = 8'h40;
          4'd3:    xlat_char = 8'h23;
          4'd4:    xlat_char = 8'h24;
          4'd5:    xlat_char = 8'h25;
          4'd6:    xlat_char = 8'h5E;
          4'd7:    xlat_char = 8'h26;
          4'd8:    xlat_char = 8'h2A;
          default: xlat_char = 8'h28;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      char_vld_q  <= 1'b0;
      char_q      <= 8'h00;
    end else begin
      char_vld_q <= 1'b0;
      if (code_valid) begin
        unique case (state_q)
          StIdle: begin
            if (code == 8'hF0) begin
              state_q <= StBrk;
            end else if (code == 8'hE0) begin
              state_q <= StExt;
            end else begin
              case (code)
                8'h12: lshift_q <= 1'b1;
                8'h59: rshift_q <= 1'b1;
                8'h14: lctrl_q  <= 1'b1;
                8'h58: begin
                  // Typematic repeats of caps lock arrive while held and must not toggle.
                  if (!caps_held_q) caps_q <= ~caps_q;
                  caps_held_q <= 1'b1;
                end
                default: begin
                  char_vld_q <= xlat_vld;
                  char_q     <= xlat_char;
                end
              endcase
            end
          end
          StExt: begin
            if (code == 8'hF0) begin
              state_q <= StExtBrk;
            end else begin
              if (code == 8'h14) rctrl_q <= 1'b1;
              state_q <= StIdle;
            end
          end
          StBrk: begin
            case (code)
              8'h12:   lshift_q    <= 1'b0;
              8'h59:   rshift_q    <= 1'b0;
              8'h14:   lctrl_q     <= 1'b0;
              8'h58:   caps_held_q <= 1'b0;
              default: ;
            endcase
            state_q <= StIdle;
          end
          StExtBrk: begin
            if (code == 8'h14) rctrl_q <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          pop, push_ok, drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DepthCnt);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign rd_data  = empty ? 8'h00 : mem[rptr_q];
  assign pop      = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign push_ok  = char_vld_q & (~full | pop);
  assign drop     = char_vld_q & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= char_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrOne;
      if (pop)     rptr_q <= rptr_q + PtrOne;
      if (push_ok && !pop)      count_q <= count_q + CntOne;
      else if (pop && !push_ok) count_q <= count_q - CntOne;
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: directed vector table, hand sequences and random traffic
// checked against a queue-based behavioural model.
module tb_ps2_key_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    code = 8'h00;
  logic          code_valid = 1'b0;
  logic          rd_en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [7:0]    rd_data;
  logic          empty, full, overflow, shift_o, ctrl_o, caps_o;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  ps2_key_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .code(code), .code_valid(code_valid), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count), .overflow(overflow),
    .ovf_clr(ovf_clr), .shift_o(shift_o), .ctrl_o(ctrl_o), .caps_o(caps_o)
  );

  always #5 clk = ~clk;

  // Behavioural model
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
  logic [7:0] spec_codes [5] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
  logic [7:0] spec_chars [5] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};
  string      shifted_syms = ")!@#$%^&*(";

  logic [7:0] m_q [$];
  bit         m_pend_v, m_ovf, m_ls, m_rs, m_lc, m_rc, m_caps, m_held, m_brk, m_ext;
  logic [7:0] m_pend_c;

  task automatic m_reset();
    m_q.delete();
    {m_pend_v, m_ovf, m_ls, m_rs, m_lc, m_rc, m_caps, m_held, m_brk, m_ext} = '0;
    m_pend_c = 8'h00;
  endtask

  function automatic void m_translate(input logic [7:0] c, output bit v, output logic [7:0] ch);
    bit sh = m_ls | m_rs;
    v  = 1'b0;
    ch = 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == c) begin
        v = 1'b1;
        if (m_lc | m_rc)     ch = 8'(1 + i);
        else if (sh ^ m_caps) ch = 8'(65 + i);
        else                 ch = 8'(97 + i);
      end
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == c) begin
        v  = 1'b1;
        ch = sh ? 8'(shifted_syms[i]) : 8'(48 + i);
      end
    for (int i = 0; i < 5; i++)
      if (spec_codes[i] == c) begin
        v  = 1'b1;
        ch = spec_chars[i];
      end
  endfunction

  task automatic m_step(input bit cv, input logic [7:0] c, input bit rd, input bit clr);
    bit pop, was_full, drop, v;
    logic [7:0] ch;
    pop      = rd && (m_q.size() > 0);
    was_full = (m_q.size() == DEPTH);
    drop     = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (m_pend_v) begin
      if (!was_full || pop) m_q.push_back(m_pend_c);
      else drop = 1'b1;
    end
    if (clr)  m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    m_pend_v = 1'b0;
    if (cv) begin
      if (m_brk) begin
        if (m_ext) begin
          if (c == 8'h14) m_rc = 1'b0;
        end else begin
          if (c == 8'h12) m_ls = 1'b0;
          if (c == 8'h59) m_rs = 1'b0;
          if (c == 8'h14) m_lc = 1'b0;
          if (c == 8'h58) m_held = 1'b0;
        end
        m_brk = 1'b0;
        m_ext = 1'b0;
      end else if (m_ext) begin
        if (c == 8'hF0) m_brk = 1'b1;
        else begin
          if (c == 8'h14) m_rc = 1'b1;
          m_ext = 1'b0;
        end
      end else if (c == 8'hF0) m_brk = 1'b1;
      else if (c == 8'hE0) m_ext = 1'b1;
      else if (c == 8'h12) m_ls = 1'b1;
      else if (c == 8'h59) m_rs = 1'b1;
      else if (c == 8'h14) m_lc = 1'b1;
      else if (c == 8'h58) begin
        if (!m_held) m_caps = ~m_caps;
        m_held = 1'b1;
      end else begin
        m_translate(c, v, ch);
        m_pend_v = v;
        m_pend_c = ch;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("rd_data", 32'(rd_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("full", 32'(full), 32'(m_q.size() == DEPTH));
    chk("count", 32'(count), 32'(m_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("shift_o", 32'(shift_o), 32'(m_ls | m_rs));
    chk("ctrl_o", 32'(ctrl_o), 32'(m_lc | m_rc));
    chk("caps_o", 32'(caps_o), 32'(m_caps));
  endtask

  task automatic cycle(input bit cv, input logic [7:0] c, input bit rd, input bit clr);
    code_valid = cv;
    code       = c;
    rd_en      = rd;
    ovf_clr    = clr;
    @(posedge clk);
    #1;
    m_step(cv, c, rd, clr);
    code_valid = 1'b0;
    rd_en      = 1'b0;
    ovf_clr    = 1'b0;
    chk_model();
  endtask

  // Directed vectors: one row per cycle, expectations sampled after that cycle's edge.
  typedef struct {
    bit         cv;
    logic [7:0] code;
    bit         rd;
    int         cnt;
    logic [7:0] head;
    logic [2:0] mods;  // {caps, ctrl, shift}
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit cv, input logic [7:0] c, input bit rd, input int cnt,
                     input logic [7:0] head, input logic [2:0] mods);
    vec_t v;
    v.cv = cv; v.code = c; v.rd = rd; v.cnt = cnt; v.head = head; v.mods = mods;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] pool [] = '{8'h1C, 8'h32, 8'h21, 8'h1A, 8'h15, 8'h44, 8'h16, 8'h45, 8'h46,
                            8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'h12, 8'h59, 8'h14, 8'h58,
                            8'hF0, 8'hF0, 8'hE0, 8'hE0, 8'h75, 8'h00};
    // 1C, F0 1C
    add(1, 8'h1C, 0, 0, 8'h00, 3'b000); add(1, 8'hF0, 0, 1, 8'h61, 3'b000);
    add(1, 8'h1C, 0, 1, 8'h61, 3'b000); add(0, 8'h00, 1, 0, 8'h00, 3'b000);
    // 12, 1C, F0 12, 1C
    add(1, 8'h12, 0, 0, 8'h00, 3'b001); add(1, 8'h1C, 0, 0, 8'h00, 3'b001);
    add(1, 8'hF0, 0, 1, 8'h41, 3'b001); add(1, 8'h12, 0, 1, 8'h41, 3'b000);
    add(1, 8'h1C, 0, 1, 8'h41, 3'b000); add(0, 8'h00, 0, 2, 8'h41, 3'b000);
    add(0, 8'h00, 1, 1, 8'h61, 3'b000); add(0, 8'h00, 1, 0, 8'h00, 3'b000);
    // caps typematic, then 1C and shift+1C
    add(1, 8'h58, 0, 0, 8'h00, 3'b100); add(1, 8'h58, 0, 0, 8'h00, 3'b100);
    add(1, 8'h58, 0, 0, 8'h00, 3'b100); add(1, 8'hF0, 0, 0, 8'h00, 3'b100);
    add(1, 8'h58, 0, 0, 8'h00, 3'b100); add(1, 8'h1C, 0, 0, 8'h00, 3'b100);
    add(1, 8'h12, 0, 1, 8'h41, 3'b101); add(1, 8'h1C, 0, 1, 8'h41, 3'b101);
    add(0, 8'h00, 0, 2, 8'h41, 3'b101); add(0, 8'h00, 1, 1, 8'h61, 3'b101);
    add(0, 8'h00, 1, 0, 8'h00, 3'b101); add(1, 8'hF0, 0, 0, 8'h00, 3'b101);
    add(1, 8'h12, 0, 0, 8'h00, 3'b100); add(1, 8'h58, 0, 0, 8'h00, 3'b000);
    add(1, 8'hF0, 0, 0, 8'h00, 3'b000); add(1, 8'h58, 0, 0, 8'h00, 3'b000);
    // right ctrl + C, release, c, then E0 75
    add(1, 8'hE0, 0, 0, 8'h00, 3'b000); add(1, 8'h14, 0, 0, 8'h00, 3'b010);
    add(1, 8'h21, 0, 0, 8'h00, 3'b010); add(1, 8'hE0, 0, 1, 8'h03, 3'b010);
    add(1, 8'hF0, 0, 1, 8'h03, 3'b010); add(1, 8'h14, 0, 1, 8'h03, 3'b000);
    add(1, 8'h21, 0, 1, 8'h03, 3'b000); add(1, 8'hE0, 0, 2, 8'h03, 3'b000);
    add(1, 8'h75, 0, 2, 8'h03, 3'b000); add(0, 8'h00, 0, 2, 8'h03, 3'b000);
    add(0, 8'h00, 1, 1, 8'h63, 3'b000); add(0, 8'h00, 1, 0, 8'h00, 3'b000);

    m_reset();
    #2;
    chk("reset_empty", 32'(empty), 32'h1);
    chk("reset_full", 32'(full), 32'h0);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_ovf", 32'(overflow), 32'h0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    chk("reset_mods", 32'({caps_o, ctrl_o, shift_o}), 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      cycle(vecs[i].cv, vecs[i].code, vecs[i].rd, 1'b0);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_head", i), 32'(rd_data), 32'(vecs[i].head));
      chk($sformatf("vec%0d_mods", i), 32'({caps_o, ctrl_o, shift_o}), 32'(vecs[i].mods));
    end

    // Overflow: nine back-to-back digits into an 8-deep FIFO
    for (int i = 0; i < 9; i++) cycle(1'b1, digit_codes[(i + 1) % 10], 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_full", 32'(full), 32'h1);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_head", 32'(rd_data), 32'h31);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'h0);
    cycle(1'b1, 8'h16, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("full_pushpop_count", 32'(count), 32'h8);
    chk("full_pushpop_head", 32'(rd_data), 32'h32);
    chk("full_pushpop_ovf", 32'(overflow), 32'h0);
    // Drop coinciding with clear: the set wins
    cycle(1'b1, 8'h1E, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_set_beats_clr", 32'(overflow), 32'h1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    // Push and pop together while empty: pop ignored
    cycle(1'b1, 8'h29, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty_pushpop_count", 32'(count), 32'h1);
    chk("empty_pushpop_head", 32'(rd_data), 32'h20);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset between F0 and 1C
    cycle(1'b1, 8'h12, 1'b0, 1'b0);
    cycle(1'b1, 8'hF0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    m_reset();
    cycle(1'b1, 8'h1C, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_mid_head", 32'(rd_data), 32'h61);
    chk("rst_mid_mods", 32'({caps_o, ctrl_o, shift_o}), 32'h0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] c;
      c = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, pool.size() - 1)];
      cycle($urandom_range(0, 1) == 1, c, $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
